// File: rtl/rc_pkg.sv
// Shared types and limits for the RC servo-PWM pulse-width receiver.
package rc_pkg;

  typedef enum logic [1:0] {ARM, IDLE, HIGH, OVER} rc_state_e;

  localparam int DEF_MIN_US     = 800;
  localparam int DEF_MAX_US     = 2200;
  localparam int DEF_TIMEOUT_US = 50000;

  // System clock cycles per 1 us tick.
  function automatic int tick_div(input int sysclk);
    return sysclk / 1000000;
  endfunction

endpackage

// File: rtl/rc_channel.sv
// One RC input: synchronizer, edge detect, pulse FSM, width/timeout counters and sticky flags.
module rc_channel
  import rc_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int MIN_US     = DEF_MIN_US,
  parameter int MAX_US     = DEF_MAX_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 rc,
  input  logic                 tick,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] width,
  output logic                 valid,
  output logic                 fresh,
  output logic                 err
);

  localparam int                   TO_W    = $clog2(TIMEOUT_US + 1);
  localparam logic [CNT_WIDTH-1:0] MIN_C   = CNT_WIDTH'(MIN_US);
  localparam logic [CNT_WIDTH-1:0] MAX_C   = CNT_WIDTH'(MAX_US);
  localparam logic [TO_W-1:0]      TO_MAX  = TO_W'(TIMEOUT_US);
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_US - 1);

  logic                 sync1, sync2, dly;
  logic                 rise, fall, in_range, capture, reject;
  rc_state_e            state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [TO_W-1:0]      to_cnt;

  // Reset high so a line already high at reset release never looks like a rising edge.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) {sync1, sync2, dly} <= 3'b111;
    else         {sync1, sync2, dly} <= {rc, sync1, sync2};
  end

  assign rise     = sync2 & ~dly;
  assign fall     = ~sync2 & dly;
  assign in_range = (cnt >= MIN_C) && (cnt <= MAX_C);
  assign capture  = (state == HIGH) && fall && in_range;
  // A too-short pulse at the fall, or a count about to pass the upper limit.
  assign reject   = (state == HIGH) && (fall ? !in_range : (tick && (cnt == MAX_C)));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state  <= ARM;
      cnt    <= '0;
      to_cnt <= '0;
      width  <= '0;
      valid  <= 1'b0;
      fresh  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ARM:  if (!sync2) state <= IDLE;
        IDLE: if (rise) begin
          state <= HIGH;
          cnt   <= '0;
        end
        HIGH: if (fall) state <= IDLE;
        else if (tick) begin
          if (cnt == MAX_C) state <= OVER;
          else              cnt   <= cnt + 1'b1;
        end
        OVER: if (fall) state <= IDLE;
        default: state <= ARM;
      endcase

      if (capture) width <= cnt;
      fresh <= (fresh & ~clear) | capture;
      err   <= (err & ~clear) | reject;

      if (capture) begin
        to_cnt <= '0;
        valid  <= 1'b1;
      end else if (tick && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST) valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rc_capture.sv
// Multi-channel RC pulse-width receiver: shared 1 us prescaler plus one rc_channel per input.
module rc_capture
  import rc_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int SYSCLK     = 25000000,
  parameter int CNT_WIDTH  = 16,
  parameter int MIN_US     = DEF_MIN_US,
  parameter int MAX_US     = DEF_MAX_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [CHANNELS-1:0]           rc_i,
  input  logic [CHANNELS-1:0]           clear_i,
  output logic [CHANNELS*CNT_WIDTH-1:0] width_o,
  output logic [CHANNELS-1:0]           valid_o,
  output logic [CHANNELS-1:0]           new_o,
  output logic [CHANNELS-1:0]           error_o
);

  localparam int            DIV      = tick_div(SYSCLK);
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  // Free-running so every channel sees the same tick phase.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)         pre <= '0;
    else if (pre == PRE_LAST) pre <= '0;
    else                    pre <= pre + 1'b1;
  end

  assign tick = (pre == PRE_LAST);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    rc_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .TIMEOUT_US(TIMEOUT_US)
    ) u_ch (
      .gclk  (clk_i),
      .grst_n(reset_n_i),
      .rc    (rc_i[k]),
      .tick  (tick),
      .clear (clear_i[k]),
      .width (width_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .valid (valid_o[k]),
      .fresh (new_o[k]),
      .err   (error_o[k])
    );
  end

endmodule

// File: tb/tb_rc_capture.sv
// Scoreboard bench for rc_capture: directed corner cases, then random pulses on all channels at once.
module tb_rc_capture;

  localparam int CH = 4, CW = 16, SYSCLK = 2000000, DIV = 2;
  localparam int MIN = 800, MAX = 2200, TMO = 4000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    rc, dir_clr, mon_clr, clear;
  logic [CH*CW-1:0] width;
  logic [CH-1:0]    valid, fresh, err;

  assign clear = dir_clr | mon_clr;
  always #5 clk = ~clk;

  rc_capture #(
    .CHANNELS(CH), .SYSCLK(SYSCLK), .CNT_WIDTH(CW),
    .MIN_US(MIN), .MAX_US(MAX), .TIMEOUT_US(TMO)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .rc_i(rc), .clear_i(clear),
    .width_o(width), .valid_o(valid), .new_o(fresh), .error_o(err)
  );

  typedef struct {bit acc; int lo; int hi;} exp_t;

  exp_t          q [CH][$];
  int            checks = 0, errors = 0;
  bit            auto_clr = 1'b0;
  logic [CH-1:0] prev_new = '0, prev_err = '0;

  function automatic int wid(input int k);
    return int'(width[k*CW +: CW]);
  endfunction

  // Reference: a pulse of t us measures t or t-1; accepted iff that lies inside [MIN, MAX].
  function automatic exp_t model(input int t_us);
    exp_t e;
    e.lo  = t_us - 1;
    e.hi  = t_us;
    e.acc = (t_us - 1 >= MIN) && (t_us <= MAX);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon_event(input int k, input bit acc);
    exp_t e;
    if (q[k].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected ch%0d %s event", k, acc ? "capture" : "error");
    end else begin
      e = q[k].pop_front();
      chk($sformatf("ch%0d event kind", k), int'(acc), int'(e.acc), int'(e.acc));
      if (acc && e.acc) begin
        chk($sformatf("ch%0d width", k), wid(k), e.lo, e.hi);
        chk($sformatf("ch%0d valid", k), int'(valid[k]), 1, 1);
      end
    end
  endtask

  // Monitor: every rising new/error flag consumes one expected event.
  always @(negedge clk) begin
    mon_clr = '0;
    for (int k = 0; k < CH; k++) begin
      if (fresh[k] && !prev_new[k]) mon_event(k, 1'b1);
      if (err[k] && !prev_err[k])   mon_event(k, 1'b0);
      if (auto_clr && ((fresh[k] && !prev_new[k]) || (err[k] && !prev_err[k]))) mon_clr[k] = 1'b1;
    end
    prev_new = fresh;
    prev_err = err;
  end

  task automatic pulse(input int k, input int hi_us, input int lo_us);
    q[k].push_back(model(hi_us));
    rc[k] = 1'b1;
    wait_cyc(hi_us * DIV);
    rc[k] = 1'b0;
    wait_cyc(lo_us * DIV);
  endtask

  task automatic rnd_chan(input int k);
    int t;
    wait_cyc(int'($urandom_range(1, 9)));
    for (int i = 0; i < 6; i++) begin
      t = int'($urandom_range(400, 2800));
      if (t == MIN || t == MAX + 1) t++;
      pulse(k, t, int'($urandom_range(20, 300)));
    end
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; rc = '0; dir_clr = '0;
    wait_cyc(3);
    chk("reset width", int'(|width), 0, 0);
    chk("reset valid", int'(|valid), 0, 0);
    chk("reset new", int'(|fresh), 0, 0);
    chk("reset error", int'(|err), 0, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // 1500 us capture with latency check
    wait_cyc(100 * DIV);
    q[0].push_back(model(1500));
    rc[0] = 1'b1;
    wait_cyc(1500 * DIV);
    rc[0] = 1'b0;
    wait_cyc(2);
    chk("latency new early", int'(fresh[0]), 0, 0);
    chk("latency width early", wid(0), 0, 0);
    wait_cyc(1);
    chk("latency new", int'(fresh[0]), 1, 1);
    chk("latency valid", int'(valid[0]), 1, 1);
    chk("latency width", wid(0), 1499, 1500);
    chk("latency no error", int'(|err), 0, 0);
    wait_cyc(100 * DIV);

    // short pulse rejected, width and new untouched
    pulse(0, 500, 100);
    chk("short error", int'(err[0]), 1, 1);
    chk("short width kept", wid(0), 1499, 1500);
    chk("short new kept", int'(fresh[0]), 1, 1);

    // overlong pulse: one error, no update at the fall, then recovery
    dir_clr[0] = 1'b1; wait_cyc(1); dir_clr[0] = 1'b0;
    chk("clear new", int'(fresh[0]), 0, 0);
    chk("clear error", int'(err[0]), 0, 0);
    q[0].push_back(model(3000));
    rc[0] = 1'b1;
    wait_cyc((MAX + 4) * DIV);
    chk("over error", int'(err[0]), 1, 1);
    dir_clr[0] = 1'b1; wait_cyc(1); dir_clr[0] = 1'b0;
    wait_cyc((3000 - MAX - 4) * DIV - 1);
    rc[0] = 1'b0;
    wait_cyc(20);
    chk("over no second error", int'(err[0]), 0, 0);
    chk("over no capture", int'(fresh[0]), 0, 0);
    chk("over width kept", wid(0), 1499, 1500);
    pulse(0, 1000, 100);
    chk("after over width", wid(0), 999, 1000);

    // timeout drops valid, keeps width
    dir_clr[0] = 1'b1; wait_cyc(1); dir_clr[0] = 1'b0;
    q[0].push_back(model(1200));
    rc[0] = 1'b1;
    wait_cyc(1200 * DIV);
    rc[0] = 1'b0;
    n = 0;
    while (!fresh[0] && n < 10) begin wait_cyc(1); n++; end
    chk("timeout capture seen", int'(fresh[0]), 1, 1);
    n = 0;
    while (valid[0] && n < (TMO + 2) * DIV) begin wait_cyc(1); n++; end
    chk("timeout cycles", n, (TMO - 1) * DIV, (TMO + 1) * DIV);
    chk("timeout valid", int'(valid[0]), 0, 0);
    chk("timeout width kept", wid(0), 1199, 1200);

    // clear coinciding with capture / error on channel 1
    q[1].push_back(model(1000));
    rc[1] = 1'b1; wait_cyc(1000 * DIV); rc[1] = 1'b0;
    wait_cyc(2); dir_clr[1] = 1'b1; wait_cyc(1);
    chk("clear+capture new", int'(fresh[1]), 1, 1);
    wait_cyc(1); dir_clr[1] = 1'b0;
    chk("next-cycle clear new", int'(fresh[1]), 0, 0);
    wait_cyc(50);
    q[1].push_back(model(300));
    rc[1] = 1'b1; wait_cyc(300 * DIV); rc[1] = 1'b0;
    wait_cyc(2); dir_clr[1] = 1'b1; wait_cyc(1);
    chk("clear+error error", int'(err[1]), 1, 1);
    wait_cyc(1); dir_clr[1] = 1'b0;
    chk("next-cycle clear error", int'(err[1]), 0, 0);
    wait_cyc(50);

    // reset mid-pulse, line still high at release
    dir_clr = '1; wait_cyc(1); dir_clr = '0;
    pulse(0, 1500, 50);
    chk("pre-reset new", int'(fresh[0]), 1, 1);
    rc[0] = 1'b1;
    wait_cyc(300 * DIV);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset width", int'(|width), 0, 0);
    chk("async reset flags", int'(|{valid, fresh, err}), 0, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(700 * DIV);
    rc[0] = 1'b0;
    wait_cyc(50);
    chk("armed no capture", int'(|fresh), 0, 0);
    chk("armed no error", int'(|err), 0, 0);
    pulse(0, 1200, 100);
    chk("post-arm width", wid(0), 1199, 1200);

    // random pulses on every channel concurrently
    dir_clr = '1; wait_cyc(1); dir_clr = '0;
    auto_clr = 1'b1;
    fork
      rnd_chan(0);
      rnd_chan(1);
      rnd_chan(2);
      rnd_chan(3);
    join
    wait_cyc(20);
    for (int k = 0; k < CH; k++) chk($sformatf("ch%0d events outstanding", k), q[k].size(), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
